// File: rtl/pacman_move_ctrl.sv
// -----------------------------------------------------------------------------
// pacman_move_ctrl
//   Tile-based movement controller for a Pac-Man style sprite. A one-hot
//   button request is remembered as a pending direction. On each movement
//   tick the sprite either steps STEP pixels along its current direction or,
//   when it sits exactly on a tile centre, first consults the wall map
//   (pending direction first, then current direction) before moving.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous active-high reset
//   move_tick  in   single-cycle movement strobe (ignored while busy)
//   btn_dir    in   [3]=left [2]=up [1]=right [0]=down, one-hot request
//   wall_row   out  wall-map lookup row (neighbour tile)
//   wall_col   out  wall-map lookup column (neighbour tile)
//   wall_hit   in   wall flag for the tile currently addressed
//   xpos/ypos  out  sprite centre in pixels
//   cur_dir    out  current one-hot direction, 0000 = stopped
//   busy       out  high whenever the FSM is not in IDLE
//
// SF/2 must be a multiple of STEP, otherwise the sprite could step over a
// tile centre and never be seen as aligned.
// -----------------------------------------------------------------------------
module pacman_move_ctrl #(
  parameter int SF      = 60,
  parameter int S_X     = 150,
  parameter int S_Y     = 34,
  parameter int COLS    = 8,
  parameter int ROWS    = 7,
  parameter int STEP    = 2,
  parameter int START_X = 180,
  parameter int START_Y = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_tick,
  input  logic [3:0] btn_dir,
  output logic [7:0] wall_row,
  output logic [7:0] wall_col,
  input  logic       wall_hit,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [3:0] cur_dir,
  output logic       busy
);

  localparam logic [9:0] SF_L    = 10'(SF);
  localparam logic [9:0] HALF_L  = 10'(SF / 2);
  localparam logic [9:0] SX_L    = 10'(S_X);
  localparam logic [9:0] SY_L    = 10'(S_Y);
  localparam logic [9:0] COLS_L  = 10'(COLS);
  localparam logic [9:0] ROWS_L  = 10'(ROWS);
  localparam logic [9:0] STEP_L  = 10'(STEP);
  localparam logic [9:0] STX_L   = 10'(START_X);
  localparam logic [9:0] STY_L   = 10'(START_Y);

  // Elaboration-time guard against a step size that can skip tile centres.
  if (((SF / 2) % STEP) != 0) begin : g_step_check
    $error("pacman_move_ctrl: SF/2 must be a multiple of STEP");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP_P = 3'd1,
    DECIDE_P = 3'd2,
    LOOKUP_C = 3'd3,
    DECIDE_C = 3'd4,
    MOVE     = 3'd5
  } state_t;

  state_t     state_r;
  logic [3:0] pend_dir_r;
  logic       tick_r;
  logic       oob_r;

  logic [9:0] dx_s;
  logic [9:0] dy_s;
  logic [9:0] tile_col_s;
  logic [9:0] tile_row_s;
  logic       aligned_s;
  logic       btn_onehot_s;
  logic [3:0] look_dir_s;
  logic [7:0] nb_row_s;
  logic [7:0] nb_col_s;
  logic       nb_oob_s;
  logic       wall_now_s;

  // Left<->right and up<->down are the bit pairs {3,1} and {2,0}.
  function automatic logic [3:0] opposite_dir(input logic [3:0] d);
    return {d[1:0], d[3:2]};
  endfunction

  // Tile coordinates and centre alignment of the current position.
  always_comb begin
    dx_s         = xpos - SX_L;
    dy_s         = ypos - SY_L;
    tile_col_s   = dx_s / SF_L;
    tile_row_s   = dy_s / SF_L;
    aligned_s    = ((dx_s % SF_L) == HALF_L) && ((dy_s % SF_L) == HALF_L);
    btn_onehot_s = (btn_dir != 4'd0) && ((btn_dir & (btn_dir - 4'd1)) == 4'd0);
    wall_now_s   = oob_r | wall_hit;
  end

  // Direction being looked up: pending in LOOKUP_P, current otherwise.
  always_comb begin
    if (state_r == LOOKUP_P) begin
      look_dir_s = pend_dir_r;
    end else begin
      look_dir_s = cur_dir;
    end
  end

  // Neighbour tile in look_dir_s; off-maze neighbours are flagged so the
  // decision treats them as walls regardless of wall_hit.
  always_comb begin
    nb_row_s = tile_row_s[7:0];
    nb_col_s = tile_col_s[7:0];
    nb_oob_s = 1'b0;
    case (look_dir_s)
      4'b1000: begin
        nb_col_s = tile_col_s[7:0] - 8'd1;
        nb_oob_s = (tile_col_s == 10'd0);
      end
      4'b0100: begin
        nb_row_s = tile_row_s[7:0] - 8'd1;
        nb_oob_s = (tile_row_s == 10'd0);
      end
      4'b0010: begin
        nb_col_s = tile_col_s[7:0] + 8'd1;
        nb_oob_s = (tile_col_s >= (COLS_L - 10'd1));
      end
      4'b0001: begin
        nb_row_s = tile_row_s[7:0] + 8'd1;
        nb_oob_s = (tile_row_s >= (ROWS_L - 10'd1));
      end
      default: begin
        nb_oob_s = 1'b1;
      end
    endcase
  end

  // Movement FSM with registered outputs and pending-direction latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      pend_dir_r <= 4'd0;
      tick_r     <= 1'b0;
      oob_r      <= 1'b0;
      wall_row   <= 8'd0;
      wall_col   <= 8'd0;
      xpos       <= STX_L;
      ypos       <= STY_L;
      cur_dir    <= 4'd0;
      busy       <= 1'b0;
    end else begin
      // Ticks are only captured in IDLE, so ticks during a sequence vanish.
      tick_r <= move_tick && (state_r == IDLE);

      case (state_r)
        IDLE: begin
          if (tick_r) begin
            if (aligned_s) begin
              if (pend_dir_r != 4'd0) begin
                state_r <= LOOKUP_P;
                busy    <= 1'b1;
              end else if (cur_dir != 4'd0) begin
                state_r <= LOOKUP_C;
                busy    <= 1'b1;
              end else begin
                state_r <= IDLE;
                busy    <= 1'b0;
              end
            end else begin
              // Between tile centres only an immediate reversal is allowed.
              if ((cur_dir != 4'd0) && (pend_dir_r == opposite_dir(cur_dir))) begin
                cur_dir    <= pend_dir_r;
                pend_dir_r <= 4'd0;
              end
              state_r <= MOVE;
              busy    <= 1'b1;
            end
          end
        end

        LOOKUP_P, LOOKUP_C: begin
          wall_row <= nb_row_s;
          wall_col <= nb_col_s;
          oob_r    <= nb_oob_s;
          state_r  <= (state_r == LOOKUP_P) ? DECIDE_P : DECIDE_C;
          busy     <= 1'b1;
        end

        DECIDE_P: begin
          if (!wall_now_s) begin
            cur_dir    <= pend_dir_r;
            pend_dir_r <= 4'd0;
            state_r    <= MOVE;
            busy       <= 1'b1;
          end else if (cur_dir != 4'd0) begin
            state_r <= LOOKUP_C;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end

        DECIDE_C: begin
          if (!wall_now_s) begin
            state_r <= MOVE;
            busy    <= 1'b1;
          end else begin
            cur_dir <= 4'd0;
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end

        MOVE: begin
          case (cur_dir)
            4'b1000: xpos <= xpos - STEP_L;
            4'b0100: ypos <= ypos - STEP_L;
            4'b0010: xpos <= xpos + STEP_L;
            4'b0001: ypos <= ypos + STEP_L;
            default: xpos <= xpos;
          endcase
          state_r <= IDLE;
          busy    <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase

      // A fresh one-hot request overrides any clear done by the FSM above.
      if (btn_onehot_s) begin
        pend_dir_r <= btn_dir;
      end
    end
  end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pacman_move_ctrl
//   Self-checking bench. A behavioural model tracks the sprite in plain
//   integer pixel/tile coordinates and predicts the outcome and latency of
//   each movement tick; the DUT is compared against it through check().
// -----------------------------------------------------------------------------
module tb_pacman_move_ctrl;

  localparam int SF = 60, S_X = 150, S_Y = 34, COLS = 8, ROWS = 7;
  localparam int STEP = 2, START_X = 180, START_Y = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       move_tick = 1'b0;
  logic [3:0] btn_dir = 4'd0;
  logic [7:0] wall_row, wall_col;
  logic       wall_hit;
  logic [9:0] xpos, ypos;
  logic [3:0] cur_dir;
  logic       busy;

  pacman_move_ctrl #(
    .SF(SF), .S_X(S_X), .S_Y(S_Y), .COLS(COLS), .ROWS(ROWS),
    .STEP(STEP), .START_X(START_X), .START_Y(START_Y)
  ) dut (
    .clk(clk), .reset(reset), .move_tick(move_tick), .btn_dir(btn_dir),
    .wall_row(wall_row), .wall_col(wall_col), .wall_hit(wall_hit),
    .xpos(xpos), .ypos(ypos), .cur_dir(cur_dir), .busy(busy)
  );

  always #5 clk = ~clk;

  // Wall map; off-maze addresses return 0 so any wall there must come
  // from the DUT's own range test.
  logic wmap [ROWS][COLS];
  always_comb begin
    if (int'(wall_row) < ROWS && int'(wall_col) < COLS)
      wall_hit = wmap[int'(wall_row)][int'(wall_col)];
    else
      wall_hit = 1'b0;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Model state.
  int         m_x, m_y;
  logic [3:0] m_cur, m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ddx(input logic [3:0] d);
    if (d == 4'b1000) return -1;
    else if (d == 4'b0010) return 1;
    else return 0;
  endfunction

  function automatic int ddy(input logic [3:0] d);
    if (d == 4'b0100) return -1;
    else if (d == 4'b0001) return 1;
    else return 0;
  endfunction

  function automatic bit blocked(input int x, input int y, input logic [3:0] d);
    int r, c;
    r = (y - S_Y) / SF + ddy(d);
    c = (x - S_X) / SF + ddx(d);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b1;
    return wmap[r][c];
  endfunction

  task automatic clear_map();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        wmap[r][c] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_x = START_X; m_y = START_Y; m_cur = 4'd0; m_pend = 4'd0;
  endtask

  task automatic press(input logic [3:0] v);
    btn_dir = v;
    step();
    btn_dir = 4'd0;
    if ($countones(v) == 1) m_pend = v;
  endtask

  // One movement tick. bb_in: button pressed during the MOVE cycle of a
  // no-lookup move; retick: raise a second tick while the DUT is busy.
  task automatic do_tick(input logic [3:0] bb_in, input bit retick);
    int ox, oy, lat, nsteps, er, ec;
    logic [3:0] bb, fdir;
    bit al;
    ox = m_x; oy = m_y; bb = bb_in; fdir = 4'd0; lat = 0;
    al = ((m_x - S_X) % SF == SF / 2) && ((m_y - S_Y) % SF == SF / 2);
    if (al) fdir = (m_pend != 4'd0) ? m_pend : m_cur;
    er = ((oy - S_Y) / SF + ddy(fdir)) & 255;
    ec = ((ox - S_X) / SF + ddx(fdir)) & 255;
    if (!al) begin
      if (m_cur != 4'd0 && m_pend != 4'd0 &&
          ddx(m_pend) == -ddx(m_cur) && ddy(m_pend) == -ddy(m_cur)) begin
        m_cur = m_pend; m_pend = 4'd0;
      end
      m_x += STEP * ddx(m_cur); m_y += STEP * ddy(m_cur);
      lat = 3;
    end else if (m_pend != 4'd0) begin
      lat = 5;
      if (!blocked(ox, oy, m_pend)) begin
        m_cur = m_pend; m_pend = 4'd0;
        m_x += STEP * ddx(m_cur); m_y += STEP * ddy(m_cur);
      end else if (m_cur != 4'd0) begin
        lat = 7;
        if (!blocked(ox, oy, m_cur)) begin
          m_x += STEP * ddx(m_cur); m_y += STEP * ddy(m_cur);
        end else m_cur = 4'd0;
      end
    end else if (m_cur != 4'd0) begin
      lat = 5;
      if (!blocked(ox, oy, m_cur)) begin
        m_x += STEP * ddx(m_cur); m_y += STEP * ddy(m_cur);
      end else m_cur = 4'd0;
    end
    if (lat != 3) bb = 4'd0;
    if ($countones(bb) == 1) m_pend = bb;

    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
    nsteps = (lat == 0) ? 3 : lat;
    for (int k = 2; k <= nsteps; k++) begin
      if (k == 3 && retick) move_tick = 1'b0;
      step();
      if (k == 2 && lat > 0) check("busy_mid", busy, 1);
      if (k == 3 && fdir != 4'd0 && lat > 0) begin
        check("wall_row", wall_row, er);
        check("wall_col", wall_col, ec);
      end
      if (k == lat - 1) begin
        check("x_before", xpos, ox);
        check("y_before", ypos, oy);
      end
      if (k == 2 && bb != 4'd0) btn_dir = bb;
      if (k == 2 && retick) move_tick = 1'b1;
    end
    btn_dir = 4'd0;
    move_tick = 1'b0;
    check("xpos", xpos, m_x);
    check("ypos", ypos, m_y);
    check("cur_dir", cur_dir, m_cur);
    check("busy_end", busy, 0);
    if (retick) begin
      for (int k = 0; k < 6; k++) step();
      check("retick_x", xpos, m_x);
      check("retick_y", ypos, m_y);
    end
  endtask

  initial begin
    clear_map();
    // Reset values.
    do_reset();
    check("rst_x", xpos, 180);
    check("rst_y", ypos, 64);
    check("rst_dir", cur_dir, 0);
    check("rst_busy", busy, 0);
    check("rst_wrow", wall_row, 0);
    check("rst_wcol", wall_col, 0);

    // Right from the start tile: one lookup of (0,1), x=182 five cycles on.
    press(4'b0010);
    do_tick(4'd0, 1'b0);
    check("first_x", xpos, 182);
    check("first_dir", cur_dir, 4'b0010);

    // Left at the maze edge: column -1 is a wall, nothing moves.
    do_reset();
    press(4'b1000);
    do_tick(4'd0, 1'b0);
    check("edge_x", xpos, 180);
    check("edge_dir", cur_dir, 0);

    // Reversal between tile centres without lookup, then a button taken
    // during MOVE reverses again on the next tick.
    do_reset();
    press(4'b0010);
    while (m_x < 190) do_tick(4'd0, 1'b0);
    press(4'b1000);
    do_tick(4'd0, 1'b0);
    check("rev_x", xpos, 188);
    check("rev_dir", cur_dir, 4'b1000);
    do_tick(4'b0010, 1'b0);
    do_tick(4'd0, 1'b0);
    check("busy_btn_dir", cur_dir, 4'b0010);

    // Aligned at 240 with pending up blocked: falls back to right, 7 cycles.
    do_reset();
    press(4'b0010);
    while (m_x < 240) do_tick(4'd0, 1'b0);
    press(4'b0100);
    do_tick(4'd0, 1'b0);
    check("fallback_x", xpos, 242);
    check("fallback_dir", cur_dir, 4'b0010);
    do_tick(4'd0, 1'b0);

    // Moving right into a wall stops; later ticks do nothing.
    do_reset();
    wmap[0][2] = 1'b1;
    press(4'b0010);
    while (m_x < 240) do_tick(4'd0, 1'b0);
    do_tick(4'd0, 1'b0);
    check("stop_dir", cur_dir, 0);
    do_tick(4'd0, 1'b0);
    do_tick(4'd0, 1'b0);
    check("stop_x", xpos, 240);
    clear_map();

    // Second tick while busy is dropped.
    do_reset();
    press(4'b0010);
    do_tick(4'd0, 1'b1);
    check("retick_once", xpos, 182);

    // Reset during DECIDE_P aborts the move.
    do_reset();
    press(4'b0001);
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
    step();
    step();
    check("dp_wrow", wall_row, 1);
    reset = 1'b1;
    step();
    check("abort_x", xpos, 180);
    check("abort_y", ypos, 64);
    check("abort_dir", cur_dir, 0);
    check("abort_busy", busy, 0);
    check("abort_wrow", wall_row, 0);
    check("abort_wcol", wall_col, 0);
    reset = 1'b0;
    m_x = START_X; m_y = START_Y; m_cur = 4'd0; m_pend = 4'd0;
    step();

    // Randomized walk over a random maze.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        wmap[r][c] = ($urandom_range(0, 9) < 3);
    wmap[0][0] = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 2) == 0) press(4'($urandom_range(0, 15)));
      do_tick(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
              $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pacman_move_ctrl.md
PACMAN_MOVE_CTRL -- requirements
Module: pacman_move_ctrl

Interface
REQ-001 SHALL have parameter SF, default 60, tile size in pixels.
REQ-002 SHALL have parameter S_X, default 150, maze left edge x in pixels.
REQ-003 SHALL have parameter S_Y, default 34, maze top edge y in pixels.
REQ-004 SHALL have parameter COLS, default 8, maze width in tiles.
REQ-005 SHALL have parameter ROWS, default 7, maze height in tiles.
REQ-006 SHALL have parameter STEP, default 2, pixels moved per move_tick.
REQ-007 SHALL have parameters START_X, default 180, and START_Y, default 64, the sprite-centre reset position.
REQ-008 SHALL have port clk, input, 1 bit, sole clock; all logic is rising-edge.
REQ-009 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-010 SHALL have port move_tick, input, 1 bit, single-cycle movement strobe.
REQ-011 SHALL have port btn_dir, input, 4 bits, one-hot request: [3]=left, [2]=up, [1]=right, [0]=down.
REQ-012 SHALL have port wall_row, output, 8 bits, wall-map lookup row.
REQ-013 SHALL have port wall_col, output, 8 bits, wall-map lookup column.
REQ-014 SHALL have port wall_hit, input, 1 bit, wall flag for the tile addressed in the previous cycle.
REQ-015 SHALL have ports xpos and ypos, outputs, 10 bits each, sprite centre in pixels.
REQ-016 SHALL have port cur_dir, output, 4 bits, current one-hot direction; 0000 means stopped.
REQ-017 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL latch btn_dir into pend_dir on any cycle where btn_dir has exactly one bit set, including while busy; zero or multi-bit values are ignored.
REQ-019 SHALL implement the FSM states IDLE, LOOKUP_P, DECIDE_P, LOOKUP_C, DECIDE_C and MOVE.
REQ-020 SHALL ignore move_tick when not in IDLE; dropped ticks are neither queued nor counted.
REQ-021 SHALL treat the sprite as aligned when (xpos-S_X) mod SF == SF/2 and (ypos-S_Y) mod SF == SF/2.
REQ-022 SHALL compute the current tile as row=(ypos-S_Y)/SF and col=(xpos-S_X)/SF, using unsigned 10-bit arithmetic.
REQ-023 SHALL, in IDLE on move_tick when not aligned, go to MOVE if pend_dir is the exact opposite of a non-zero cur_dir (setting cur_dir to pend_dir and clearing pend_dir), else go to MOVE unchanged.
REQ-024 SHALL, in IDLE on move_tick when aligned, go to LOOKUP_P if pend_dir is non-zero, else to LOOKUP_C if cur_dir is non-zero, else stay in IDLE.
REQ-025 SHALL, in LOOKUP_P or LOOKUP_C, register wall_row/wall_col as the neighbour tile in pend_dir or cur_dir respectively, and hold them stable until the following DECIDE state completes.
REQ-026 SHALL treat a neighbour outside 0..ROWS-1 or 0..COLS-1 as a wall without using wall_hit, while still passing through the DECIDE state.
REQ-027 SHALL, in DECIDE_P: if clear, set cur_dir to pend_dir, clear pend_dir and go to MOVE; if wall, go to LOOKUP_C when cur_dir is non-zero, else to IDLE; in both wall cases pend_dir is retained.
REQ-028 SHALL, in DECIDE_C: if clear, go to MOVE; if wall, set cur_dir to 0000 and go to IDLE.
REQ-029 SHALL, in MOVE, add or subtract STEP on the axis of cur_dir and return to IDLE; the new position is visible the cycle after MOVE.
REQ-030 SHALL produce a position update 3 cycles (no lookup), 5 cycles (one lookup) or 7 cycles (two lookups) after the move_tick cycle.
REQ-031 SHALL require SF/2 to be a multiple of STEP so that the sprite cannot skip alignment.

Reset
REQ-032 SHALL, on reset, set state=IDLE, xpos=START_X, ypos=START_Y, cur_dir=0000, pend_dir=0000, wall_row=0, wall_col=0 and busy=0; reset asserted mid-sequence aborts without a position change.

Verification
REQ-033 SHALL verify: reset, btn_dir=0010, wall_hit=0, one tick -> lookup (0,1), cur_dir=0010, xpos=182 five cycles after the tick.
REQ-034 SHALL verify: at (180,64), btn_dir=1000 -> column -1 is treated as a wall, wall_hit is ignored, cur_dir stays 0000 and the position is unchanged.
REQ-035 SHALL verify: moving right at x=190, btn_dir=1000, tick -> cur_dir=1000 and x=188 three cycles later, with no lookup.
REQ-036 SHALL verify: moving right at 240 (aligned), pend=up, up-tile wall=1, right-tile wall=0 -> x=242, cur_dir stays right, pend stays up, seven cycles after the tick.
REQ-037 SHALL verify: moving right, right-tile wall=1 -> cur_dir=0000, and subsequent ticks leave the position unchanged.
REQ-038 SHALL verify: a second move_tick while busy is ignored, and reset asserted during DECIDE_P returns all outputs to their reset values the next cycle.
